// File: rtl/step_dispatcher.sv
// Step dispatcher: turns each new project step code into a one-cycle start
// strobe for the matching subsystem and supervises its done handshake.
module step_dispatcher #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned CNT_W          = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] step_code,
  input  logic [3:0] sub_done,
  input  logic       clear_err,
  output logic [3:0] sub_start,
  output logic [7:0] active_step,
  output logic       busy,
  output logic       step_ok,
  output logic       timeout_err,
  output logic       bad_step,
  output logic [3:0] retry_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RETRY = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       RETRY_LIMIT = (MAX_RETRY > 15) ? 4'd15 : 4'(MAX_RETRY);

  logic [2:0]       state_q, state_d;
  logic [7:0]       prev_code_q, prev_code_d;
  logic [7:0]       active_step_q, active_step_d;
  logic [3:0]       retry_count_q, retry_count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sub_start_q, sub_start_d;
  logic             busy_q, busy_d;
  logic             step_ok_q, step_ok_d;
  logic             timeout_err_q, timeout_err_d;
  logic             bad_step_q, bad_step_d;
  logic             set_bad, set_tmo;
  logic [3:0]       new_hot, act_hot;

  // Codes 1..4 map to one subsystem bit; anything else is invalid.
  function automatic logic [3:0] step_onehot(input logic [7:0] code);
    case (code)
      8'd1:    step_onehot = 4'b0001;
      8'd2:    step_onehot = 4'b0010;
      8'd3:    step_onehot = 4'b0100;
      8'd4:    step_onehot = 4'b1000;
      default: step_onehot = 4'b0000;
    endcase
  endfunction

  // Next-state logic; a changed step code preempts whatever is in progress.
  always_comb begin
    state_d       = state_q;
    prev_code_d   = step_code;
    active_step_d = active_step_q;
    retry_count_d = retry_count_q;
    cnt_d         = cnt_q;
    step_ok_d     = 1'b0;
    set_bad       = 1'b0;
    set_tmo       = 1'b0;
    new_hot       = step_onehot(step_code);
    act_hot       = step_onehot(active_step_q);
    if (step_code != prev_code_q) begin
      if (new_hot != 4'b0000) begin
        state_d       = S_START;
        active_step_d = step_code;
        retry_count_d = 4'd0;
      end else begin
        state_d       = S_IDLE;
        active_step_d = 8'd0;
        set_bad       = 1'b1;
      end
    end else begin
      case (state_q)
        S_START: begin
          state_d = S_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end
        S_WAIT: begin
          cnt_d = cnt_q + CNT_ONE;
          // A done pulse on the final count still counts as success.
          if ((sub_done & act_hot) != 4'b0000) begin
            state_d   = S_DONE;
            step_ok_d = 1'b1;
          end else if (cnt_d == CNT_LAST) begin
            if (retry_count_q < RETRY_LIMIT) begin
              state_d = S_RETRY;
            end else begin
              state_d = S_FAULT;
              set_tmo = 1'b1;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_RETRY: begin
          state_d = S_START;
          if (retry_count_q != 4'd15) begin
            retry_count_d = retry_count_q + 4'd1;
          end else begin
            retry_count_d = retry_count_q;
          end
        end
        S_IDLE, S_DONE, S_FAULT: state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_START) begin
      sub_start_d = step_onehot(active_step_d);
    end else begin
      sub_start_d = 4'b0000;
    end
    busy_d        = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_RETRY);
    timeout_err_d = set_tmo | (timeout_err_q & ~clear_err);
    bad_step_d    = set_bad | (bad_step_q & ~clear_err);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      prev_code_q   <= 8'd0;
      active_step_q <= 8'd0;
      retry_count_q <= 4'd0;
      cnt_q         <= {CNT_W{1'b0}};
      sub_start_q   <= 4'b0000;
      busy_q        <= 1'b0;
      step_ok_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      bad_step_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_code_q   <= prev_code_d;
      active_step_q <= active_step_d;
      retry_count_q <= retry_count_d;
      cnt_q         <= cnt_d;
      sub_start_q   <= sub_start_d;
      busy_q        <= busy_d;
      step_ok_q     <= step_ok_d;
      timeout_err_q <= timeout_err_d;
      bad_step_q    <= bad_step_d;
    end
  end

  assign sub_start   = sub_start_q;
  assign active_step = active_step_q;
  assign busy        = busy_q;
  assign step_ok     = step_ok_q;
  assign timeout_err = timeout_err_q;
  assign bad_step    = bad_step_q;
  assign retry_count = retry_count_q;

endmodule

// File: tb/tb_step_dispatcher.sv
// Bench for step_dispatcher: directed scenarios plus random traffic checked
// against an attempt/age model of the dispatch protocol.
module tb_step_dispatcher;
  localparam int T    = 8;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] step_code = 8'd2;
  logic [3:0] sub_done = 4'b0000;
  logic       clear_err = 1'b0;
  logic [3:0] sub_start;
  logic [7:0] active_step;
  logic       busy, step_ok, timeout_err, bad_step;
  logic [3:0] retry_count;

  int total = 0;
  int bad = 0;

  // Model: running attempt, its age (0 = strobe cycle, T = retry cycle).
  logic [7:0] m_prev = 8'd0;
  int         m_act = 0, m_age = 0, m_retry = 0;
  logic       m_run = 1'b0;
  logic [3:0] e_start = 4'b0000;
  logic       e_ok = 1'b0, e_bad = 1'b0, e_terr = 1'b0;

  step_dispatcher #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MAXR), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .step_code(step_code), .sub_done(sub_done),
    .clear_err(clear_err), .sub_start(sub_start), .active_step(active_step),
    .busy(busy), .step_ok(step_ok), .timeout_err(timeout_err),
    .bad_step(bad_step), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_prev = 8'd0; m_act = 0; m_age = 0; m_retry = 0; m_run = 1'b0;
    e_start = 4'b0000; e_ok = 1'b0; e_bad = 1'b0; e_terr = 1'b0;
  endtask

  task automatic tick();
    logic sb, st;
    sb = 1'b0; st = 1'b0; e_start = 4'b0000; e_ok = 1'b0;
    if (step_code != m_prev) begin
      if (step_code >= 8'd1 && step_code <= 8'd4) begin
        m_act = int'(step_code); m_run = 1'b1; m_age = 0; m_retry = 0;
        e_start = 4'b0001 << (m_act - 1);
      end else begin
        m_act = 0; m_run = 1'b0; sb = 1'b1;
      end
    end else if (m_run) begin
      if (m_age == T) begin
        m_retry = (m_retry < 15) ? m_retry + 1 : 15; m_age = 0;
        e_start = 4'b0001 << (m_act - 1);
      end else if (m_age != 0 && sub_done[m_act-1]) begin
        m_run = 1'b0; e_ok = 1'b1;
      end else if (m_age == T - 1) begin
        if (m_retry < MAXR) m_age = T;
        else begin m_run = 1'b0; st = 1'b1; end
      end else begin
        m_age++;
      end
    end
    e_bad  = sb | (e_bad & ~clear_err);
    e_terr = st | (e_terr & ~clear_err);
    m_prev = step_code;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if ({sub_start, active_step, busy, step_ok, timeout_err, bad_step, retry_count} !== 24'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {sub_start, active_step, busy, step_ok, timeout_err, bad_step, retry_count}); end
    rst = 1'b1;
    model_reset();
    tick();
    total++; if (sub_start !== 4'b0010) begin bad++; $display("FAIL rst_strobe got=%b want=0010", sub_start); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
    total++; if (active_step !== 8'd2) begin bad++; $display("FAIL rst_active got=%0d want=2", active_step); end
    tick();
    total++; if (sub_start !== 4'b0000) begin bad++; $display("FAIL strobe_width got=%b want=0000", sub_start); end
    repeat (3) tick();
    sub_done = 4'b0010; tick(); sub_done = 4'b0000;
    total++; if (step_ok !== 1'b1) begin bad++; $display("FAIL done_ok got=%b want=1", step_ok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_busy got=%b want=0", busy); end
    tick();
    total++; if (step_ok !== 1'b0) begin bad++; $display("FAIL ok_width got=%b want=0", step_ok); end
  endtask

  task automatic test_preempt();
    int oks;
    step_code = 8'd3; tick();
    repeat (3) tick();
    step_code = 8'd2; tick();
    total++; if (sub_start !== 4'b0010) begin bad++; $display("FAIL pre_first got=%b want=0010", sub_start); end
    repeat (2) tick();
    step_code = 8'd3; tick();
    total++; if (sub_start !== 4'b0100) begin bad++; $display("FAIL pre_strobe got=%b want=0100", sub_start); end
    oks = (step_ok === 1'b1) ? 1 : 0;
    sub_done = 4'b0010; tick(); sub_done = 4'b0000;
    oks += (step_ok === 1'b1) ? 1 : 0;
    tick();
    oks += (step_ok === 1'b1) ? 1 : 0;
    total++; if (oks !== 0) begin bad++; $display("FAIL pre_no_ok got=%0d want=0", oks); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_busy got=%b want=1", busy); end
    sub_done = 4'b0100; tick(); sub_done = 4'b0000;
    total++; if (step_ok !== 1'b1) begin bad++; $display("FAIL pre_ok got=%b want=1", step_ok); end
  endtask

  task automatic test_timeout();
    int strobes[$];
    int want[3] = '{1, 10, 19};
    step_code = 8'd4;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (sub_start !== 4'b0000) strobes.push_back(k);
      if (k == 1 || k == 10 || k == 19) begin
        total++; if (sub_start !== 4'b1000) begin bad++; $display("FAIL tmo_bit k=%0d got=%b want=1000", k, sub_start); end
      end
      if (k == 26) begin
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", timeout_err); end
      end
    end
    total++; if (strobes.size() !== 3) begin bad++; $display("FAIL tmo_count got=%0d want=3", strobes.size()); end
    for (int i = 0; i < 3 && i < strobes.size(); i++) begin
      total++; if (strobes[i] !== want[i]) begin bad++; $display("FAIL tmo_cycle got=%0d want=%0d", strobes[i], want[i]); end
    end
    total++; if (retry_count !== 4'd2) begin bad++; $display("FAIL tmo_retry got=%0d want=2", retry_count); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b want=1", timeout_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%b want=0", busy); end
  endtask

  task automatic test_coincident();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL clr_tmo got=%b want=0", timeout_err); end
    step_code = 8'd3;
    for (int k = 1; k <= 30; k++) begin
      if (k == 27) sub_done = 4'b0100;
      tick();
      sub_done = 4'b0000;
      if (k == 27) begin
        total++; if (step_ok !== 1'b1) begin bad++; $display("FAIL coin_ok got=%b want=1", step_ok); end
      end
    end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL coin_err got=%b want=0", timeout_err); end
    total++; if (retry_count !== 4'd2) begin bad++; $display("FAIL coin_retry got=%0d want=2", retry_count); end
  endtask

  task automatic test_bad_step();
    step_code = 8'd7; tick();
    total++; if (bad_step !== 1'b1) begin bad++; $display("FAIL bad_set got=%b want=1", bad_step); end
    total++; if (sub_start !== 4'b0000) begin bad++; $display("FAIL bad_strobe got=%b want=0000", sub_start); end
    total++; if (active_step !== 8'd0) begin bad++; $display("FAIL bad_active got=%0d want=0", active_step); end
    tick();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    total++; if (bad_step !== 1'b0) begin bad++; $display("FAIL bad_clear got=%b want=0", bad_step); end
    step_code = 8'd1; tick();
    total++; if (sub_start !== 4'b0001) begin bad++; $display("FAIL bad_then_valid got=%b want=0001", sub_start); end
  endtask

  task automatic test_reset_mid();
    step_code = 8'd3; tick();
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    total++; if ({sub_start, active_step, busy, step_ok, timeout_err, bad_step, retry_count} !== 24'd0) begin
      bad++; $display("FAIL mid_reset got=%h want=0", {sub_start, active_step, busy, step_ok, timeout_err, bad_step, retry_count}); end
    model_reset();
    #2 rst = 1'b1;
    tick();
    total++; if (sub_start !== 4'b0100) begin bad++; $display("FAIL mid_restart got=%b want=0100", sub_start); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) step_code = 8'($urandom_range(0, 5));
      sub_done  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      clear_err = ($urandom_range(0, 11) == 0);
      tick();
      total++; if (sub_start !== e_start) begin bad++; $display("FAIL rnd_start n=%0d got=%b want=%b", n, sub_start, e_start); end
      total++; if (active_step !== 8'(m_act)) begin bad++; $display("FAIL rnd_active n=%0d got=%0d want=%0d", n, active_step, m_act); end
      total++; if (busy !== m_run) begin bad++; $display("FAIL rnd_busy n=%0d got=%b want=%b", n, busy, m_run); end
      total++; if (step_ok !== e_ok) begin bad++; $display("FAIL rnd_ok n=%0d got=%b want=%b", n, step_ok, e_ok); end
      total++; if (timeout_err !== e_terr) begin bad++; $display("FAIL rnd_terr n=%0d got=%b want=%b", n, timeout_err, e_terr); end
      total++; if (bad_step !== e_bad) begin bad++; $display("FAIL rnd_bad n=%0d got=%b want=%b", n, bad_step, e_bad); end
      total++; if (retry_count !== 4'(m_retry)) begin bad++; $display("FAIL rnd_retry n=%0d got=%0d want=%0d", n, retry_count, m_retry); end
    end
    sub_done = 4'b0000; clear_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preempt();
    test_timeout();
    test_coincident();
    test_bad_step();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
